// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
// Latency: n/a (compile-time constants and a constant function only).
// Backpressure: n/a.
package seq_det_pkg;

    // Reset-time configuration defaults (the old fixed "000" detector).
    localparam int   DEF_LEN     = 3;
    localparam logic DEF_OVERLAP = 1'b1;

    // Overlap mode encodings for the overlap configuration bit.
    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    // Ceiling log2, usable in parameter defaults (clog2(9) = 4).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear; clear is applied before increment.
// Latency: count reflects inc/clr one clock after they are sampled.
// Backpressure: none; inc/clr are accepted every cycle.
//
// Ports:
//   clk, rst : clock and asynchronous active-high reset (count -> 0)
//   inc      : add one this cycle (ignored once the counter is at its maximum)
//   clr      : synchronous clear; with inc in the same cycle the result is 1
//   count    : current count value
module seq_sat_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            // Clear first, then count the coincident event.
            count <= inc ? CNT_ONE : '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with runtime-loadable pattern, length and overlap mode.
// Latency: match pulses one clock after the edge that samples the completing bit.
// Backpressure: none; a bit is consumed on every in_valid cycle, cfg_load wins over in_valid.
//
// Ports:
//   clk, rst     : clock and asynchronous active-high reset (restores DEF_* config)
//   in_valid     : in_bit is sampled this cycle
//   in_bit       : serial data bit
//   cfg_load     : latch cfg_pattern/cfg_len/cfg_overlap, flush history
//   cfg_pattern  : pattern, bit len-1 arrives first and bit 0 last
//   cfg_len      : pattern length, legal range 1..PAT_W
//   cfg_overlap  : 1 = overlapping matches, 0 = bits of a match are not reused
//   count_clr    : synchronous clear of match_count
//   match        : registered one-cycle match pulse
//   match_count  : saturating number of matches
//   cfg_err      : latched config has an illegal length (no matching while set)
//   fill         : number of valid history bits
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = 8,
    parameter int               LEN_W       = seq_det_pkg::clog2(PAT_W + 1),
    parameter int               CNT_W       = 16,
    parameter logic [PAT_W-1:0] DEF_PATTERN = '0,
    parameter int               DEF_LEN     = seq_det_pkg::DEF_LEN,
    parameter logic             DEF_OVERLAP = seq_det_pkg::DEF_OVERLAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             count_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_err,
    output logic [LEN_W-1:0] fill
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    // Latched configuration.
    logic [PAT_W-1:0] pattern_q;
    logic [LEN_W-1:0] len_q;
    logic             overlap_q;

    // History: hist_q[0] is the most recently sampled bit.
    logic [PAT_W-1:0] hist_q;
    logic [LEN_W-1:0] fill_q;

    // Next-state values for a bit sampled this cycle.
    logic [PAT_W-1:0] hist_n;
    logic [LEN_W-1:0] fill_n;
    logic [PAT_W-1:0] len_mask;
    logic             pat_eq;
    logic             hit;

    // The oldest history bit shifts out and is never compared.
    logic unused_hist_msb;
    assign unused_hist_msb = hist_q[PAT_W-1];

    assign hist_n = {hist_q[PAT_W-2:0], in_bit};
    assign fill_n = (fill_q == FILL_MAX) ? FILL_MAX : (fill_q + LEN_ONE);

    // Only the low len bits of history and pattern take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign pat_eq = (((hist_n ^ pattern_q) & len_mask) == '0);

    // A load in the same cycle discards the bit, so it can never complete a match.
    assign hit = in_valid && !cfg_load && !cfg_err && (fill_n >= len_q) && pat_eq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            cfg_err   <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            match     <= 1'b0;
        end else if (cfg_load) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
            cfg_err   <= (cfg_len == '0) || (cfg_len > FILL_MAX);
            hist_q    <= '0;
            fill_q    <= '0;
            match     <= 1'b0;
        end else if (in_valid) begin
            hist_q <= hist_n;
            // Non-overlapping mode: bits consumed by a match cannot start the next one.
            fill_q <= (hit && (overlap_q == OVL_OFF)) ? '0 : fill_n;
            match  <= hit;
        end else begin
            match <= 1'b0;
        end
    end

    assign fill = fill_q;

    seq_sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit),
        .clr   (count_clr),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_bit;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             count_clr;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             cfg_err;
    logic [LEN_W-1:0] fill;

    seq_detector_param #(
        .PAT_W       (PAT_W),
        .LEN_W       (LEN_W),
        .CNT_W       (CNT_W),
        .DEF_PATTERN (8'b0000_0000),
        .DEF_LEN     (3),
        .DEF_OVERLAP (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .count_clr   (count_clr),
        .match       (match),
        .match_count (match_count),
        .cfg_err     (cfg_err),
        .fill        (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic m;
        int   cnt;
        int   fill;
        logic err;
        string tag;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: a list of the bits received since the last flush.
    bit m_hist[$];
    int m_pat;
    int m_len;
    bit m_ovl;
    bit m_err;
    int m_cnt;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_pat = 0;
        m_len = 3;
        m_ovl = 1'b1;
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    // Apply one cycle's inputs to the model and queue the expected outputs.
    task automatic model_step(input bit v, input bit b, input bit ld, input int pat,
                              input int len, input bit ovl, input bit clr, input string tag);
        exp_t e;
        bit   hit;
        hit = 1'b0;
        if (ld) begin
            m_pat = pat;
            m_len = len;
            m_ovl = ovl;
            m_err = (len == 0) || (len > PAT_W);
            m_hist.delete();
        end else if (v) begin
            m_hist.push_back(b);
            if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
            if (!m_err && m_hist.size() >= m_len) begin
                hit = 1'b1;
                // Last received bit corresponds to pattern bit 0.
                for (int k = 0; k < m_len; k++)
                    if (m_hist[m_hist.size() - 1 - k] != ((m_pat >> k) & 1)) hit = 1'b0;
            end
            if (hit && !m_ovl) m_hist.delete();
        end
        if (clr) m_cnt = 0;
        if (hit && m_cnt < CNT_MAX) m_cnt++;
        e.m    = hit;
        e.cnt  = m_cnt;
        e.fill = m_hist.size();
        e.err  = m_err;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit v, input bit b, input bit ld, input int pat,
                       input int len, input bit ovl, input bit clr, input string tag);
        @(negedge clk);
        in_valid    = v;
        in_bit      = b;
        cfg_load    = ld;
        cfg_pattern = pat[PAT_W-1:0];
        cfg_len     = len[LEN_W-1:0];
        cfg_overlap = ovl;
        count_clr   = clr;
        model_step(v, b, ld, pat, len, ovl, clr, tag);
    endtask

    task automatic bit_in(input bit b, input string tag);
        cyc(1'b1, b, 1'b0, 0, 0, 1'b0, 1'b0, tag);
    endtask

    task automatic idle(input string tag);
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, tag);
    endtask

    task automatic load(input int pat, input int len, input bit ovl, input string tag);
        cyc(1'b0, 1'b0, 1'b1, pat, len, ovl, 1'b0, tag);
    endtask

    // Monitor: outputs are presented every cycle; compare after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, ".match"}, int'(match), int'(e.m));
            check({e.tag, ".match_count"}, int'(match_count), e.cnt);
            check({e.tag, ".fill"}, int'(fill), e.fill);
            check({e.tag, ".cfg_err"}, int'(cfg_err), int'(e.err));
        end
    end

    initial begin
        bit seq2[7];
        int drain;
        rst = 1'b1;
        in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; count_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.match", int'(match), 0);
        check("reset.match_count", int'(match_count), 0);
        check("reset.fill", int'(fill), 0);
        check("reset.cfg_err", int'(cfg_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: default "000", overlapping
        bit_in(1, "t1"); bit_in(0, "t1"); bit_in(0, "t1");
        bit_in(0, "t1"); bit_in(0, "t1"); bit_in(1, "t1");
        bit_in(1, "t1_fill"); bit_in(1, "t1_fill"); bit_in(1, "t1_fill");

        // 2: 1011 overlapping
        seq2 = '{1, 0, 1, 1, 0, 1, 1};
        cyc(1'b0, 1'b0, 1'b1, 'b1011, 4, 1'b1, 1'b1, "t2_load");
        foreach (seq2[i]) bit_in(seq2[i], "t2");

        // 3: 1011 non-overlapping
        load('b1011, 4, 1'b0, "t3_load");
        foreach (seq2[i]) bit_in(seq2[i], "t3");
        bit_in(1, "t3"); bit_in(0, "t3"); bit_in(1, "t3"); bit_in(1, "t3");

        // 4: idle gaps, then load coincident with a valid bit
        load('b000, 3, 1'b1, "t4_load");
        for (int i = 0; i < 3; i++) begin
            bit_in(0, "t4");
            repeat (i + 1) idle("t4_gap");
        end
        bit_in(0, "t4");
        cyc(1'b1, 1'b0, 1'b1, 'b000, 3, 1'b1, 1'b0, "t4_ld_valid");

        // 5: saturation, clear-with-match, illegal length
        load('b1, 1, 1'b1, "t5_load");
        for (int i = 0; i < 20; i++) bit_in(1, "t5_sat");
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, "t5_clr_match");
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, "t5_clr_only");
        load('b1, 0, 1'b1, "t5_err");
        for (int i = 0; i < 4; i++) bit_in(1, "t5_err");
        load('b1, 9, 1'b1, "t5_err9");
        bit_in(1, "t5_err9");
        load('b000, 3, 1'b1, "t5_legal");
        for (int i = 0; i < 3; i++) bit_in(0, "t5_legal");

        // 6: asynchronous reset mid-stream
        bit_in(0, "t6"); bit_in(0, "t6");
        @(negedge clk);
        #2;
        rst = 1'b1;
        in_valid = 1'b0; cfg_load = 1'b0; count_clr = 1'b0;
        #1;
        check("t6_async.match", int'(match), 0);
        check("t6_async.match_count", int'(match_count), 0);
        check("t6_async.fill", int'(fill), 0);
        model_reset();
        // Expectation for the edge while rst is held.
        model_step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, "t6_rst");
        @(negedge clk);
        rst = 1'b0;
        bit_in(0, "t6_after"); bit_in(0, "t6_after"); bit_in(0, "t6_after");

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3)
                cyc(1'b0, 1'b0, 1'b1, $urandom_range(0, 255), $urandom_range(0, 10),
                    1'($urandom_range(0, 1)), 1'b0, "rnd_load");
            else if (r < 5)
                load($urandom_range(0, 3), $urandom_range(1, 2), 1'($urandom_range(0, 1)), "rnd_short");
            else if (r < 7)
                cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 255),
                    $urandom_range(1, 8), 1'($urandom_range(0, 1)), 1'b0, "rnd_ld_valid");
            else
                cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0, 0, 0, 1'b0,
                    1'($urandom_range(0, 29) == 0), "rnd");
        end
        idle("tail");

        drain = 0;
        while (exp_q.size() > 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
